// File: rtl/vac_div_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel divider stimulus.
// Holds the sequencer state encoding, the divider-ratio constant and the quadrant decode.
package vac_div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LUT,
      MUL,
      DIV,
      PRESENT
   } state_t;

   typedef struct packed {
      logic mirror;
      logic negate;
   } quad_t;

   // K = floor(R2*2^16/(R1+R2) + 0.5) in Q0.16, done in integers to avoid real rounding.
   function automatic int calc_k(input int r1, input int r2);
      longint num;
      longint den;
      num = longint'(r2) * 64'sd131072 + longint'(r1 + r2);
      den = 64'sd2 * longint'(r1 + r2);
      return int'(num / den);
   endfunction

   function automatic quad_t quad_decode(input logic [1:0] q);
      quad_t d;
      d.mirror = q[0];
      d.negate = q[1];
      return d;
   endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave sine ROM: mirrors the index in odd quadrants and negates
// in the lower half-plane. Contents are computed when the design is elaborated.
module sine_quarter_lut
   import vac_div_pkg::*;
#(
   parameter int DW     = 16,
   parameter int LUT_AW = 8
) (
   input  logic                 clk,
   input  logic [1:0]           i_quad,
   input  logic [LUT_AW-1:0]    i_idx,
   output logic signed [DW-1:0] o_sample
);

   localparam int DEPTH = (1 << LUT_AW) + 1;
   localparam logic [LUT_AW:0] FULL = (LUT_AW+1)'(1 << LUT_AW);

   // Taylor series keeps the elaboration-time evaluation to plain real arithmetic.
   function automatic logic [DW-1:0] lut_val(input int j);
      real x;
      real term;
      real s;
      x    = 3.14159265358979323846 / 2.0 * real'(j) / real'(1 << LUT_AW);
      term = x;
      s    = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
         s    = s + term;
      end
      return DW'(int'(real'((1 << (DW - 1)) - 1) * s));
   endfunction

   logic [DW-1:0]   w_rom [0:DEPTH-1];
   quad_t           w_qd;
   logic [LUT_AW:0] w_addr;
   logic signed [DW-1:0] r_sample;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [DW-1:0] LV = lut_val(gi);
      assign w_rom[gi] = LV;
   end

   assign w_qd   = quad_decode(i_quad);
   assign w_addr = w_qd.mirror ? (FULL - {1'b0, i_idx}) : {1'b0, i_idx};

   always_ff @(posedge clk) begin
      r_sample <= w_qd.negate ? -$signed(w_rom[w_addr]) : $signed(w_rom[w_addr]);
   end

   assign o_sample = r_sample;

endmodule

// File: rtl/vac_divider_stim.sv
// Multi-channel sampled-sine source feeding a fixed R2/(R1+R2) divider; each tick
// snapshots every channel and streams (vin, vout) one channel per beat.
module vac_divider_stim
   import vac_div_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int DW     = 16,
   parameter int PW     = 24,
   parameter int LUT_AW = 8,
   parameter int R1_OHM = 50,
   parameter int R2_OHM = 50,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 cfg_we,
   input  logic [CW-1:0]        cfg_ch,
   input  logic [PW-1:0]        cfg_ftw,
   input  logic [PW-1:0]        cfg_phase,
   input  logic [DW-2:0]        cfg_amp,
   input  logic                 cfg_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_ch,
   output logic signed [DW-1:0] out_vin,
   output logic signed [DW-1:0] out_vout,
   output logic                 overrun,
   input  logic                 ovr_clr
);

   localparam logic signed [17:0] K_S = 18'(calc_k(R1_OHM, R2_OHM));

   logic [PW-1:0] r_acc   [NCH];
   logic [PW-1:0] r_ftw   [NCH];
   logic [PW-1:0] r_phase [NCH];
   logic [DW-2:0] r_amp   [NCH];
   logic          r_en    [NCH];
   logic [PW-1:0] r_ph    [NCH];
   logic [DW-2:0] r_amp_s [NCH];
   logic          r_en_s  [NCH];

   state_t               r_state;
   logic [CW-1:0]        r_ch;
   logic signed [DW-1:0] r_vin_int;

   logic                   w_accept;
   logic [PW-1:0]          w_ph;
   logic [LUT_AW+1:0]      w_top;
   logic signed [DW-1:0]   w_s;
   logic signed [2*DW-1:0] w_prod;
   logic signed [DW-1:0]   w_vin;
   logic signed [DW+17:0]  w_vprod;
   logic signed [DW-1:0]   w_vout;

   assign w_accept = tick && (r_state == IDLE);

   // The tick samples pre-write cfg and pre-increment acc because all updates are non-blocking.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_acc[gi]   <= '0;
            r_ftw[gi]   <= '0;
            r_phase[gi] <= '0;
            r_amp[gi]   <= '0;
            r_en[gi]    <= 1'b0;
            r_ph[gi]    <= '0;
            r_amp_s[gi] <= '0;
            r_en_s[gi]  <= 1'b0;
         end else begin
            if (tick && r_en[gi])
               r_acc[gi] <= r_acc[gi] + r_ftw[gi];
            if (cfg_we && (cfg_ch == CW'(gi))) begin
               r_ftw[gi]   <= cfg_ftw;
               r_phase[gi] <= cfg_phase;
               r_amp[gi]   <= cfg_amp;
               r_en[gi]    <= cfg_en;
            end
            if (w_accept) begin
               r_ph[gi]    <= r_acc[gi] + r_phase[gi];
               r_amp_s[gi] <= r_amp[gi];
               r_en_s[gi]  <= r_en[gi];
            end
         end
      end
   end

   assign w_ph  = r_ph[r_ch];
   assign w_top = (LUT_AW+2)'(w_ph >> (PW - LUT_AW - 2));

   sine_quarter_lut #(
      .DW     (DW),
      .LUT_AW (LUT_AW)
   ) u_lut (
      .clk      (clk),
      .i_quad   (w_top[LUT_AW+1:LUT_AW]),
      .i_idx    (w_top[LUT_AW-1:0]),
      .o_sample (w_s)
   );

   assign w_prod  = (2*DW)'(w_s) * (2*DW)'($signed({1'b0, r_amp_s[r_ch]}));
   assign w_vin   = DW'(w_prod >>> (DW - 1));
   assign w_vprod = (DW+18)'(r_vin_int) * (DW+18)'(K_S);
   assign w_vout  = DW'(w_vprod >>> 16);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ch      <= '0;
         r_vin_int <= '0;
         out_valid <= 1'b0;
         out_vin   <= '0;
         out_vout  <= '0;
         overrun   <= 1'b0;
      end else begin
         if (tick && (r_state != IDLE))
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;

         case (r_state)
            IDLE: begin
               if (tick) begin
                  r_ch    <= '0;
                  r_state <= LUT;
               end
            end
            LUT: r_state <= MUL;
            MUL: begin
               r_vin_int <= r_en_s[r_ch] ? w_vin : '0;
               r_state   <= DIV;
            end
            DIV: begin
               out_vin   <= r_vin_int;
               out_vout  <= w_vout;
               out_valid <= 1'b1;
               r_state   <= PRESENT;
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (r_ch == CW'(NCH - 1)) begin
                     r_state <= IDLE;
                  end else begin
                     r_ch    <= r_ch + 1'b1;
                     r_state <= LUT;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_ch = r_ch;

endmodule

// File: tb/tb_vac_divider_stim.sv
// Scoreboard bench for vac_divider_stim: a behavioural phase/sine/divider model predicts
// each frame at tick time; beats are popped and compared as the stream delivers them.
module tb_vac_divider_stim;

   localparam int  NCH  = 2;
   localparam int  KA   = 32768;
   localparam int  KB   = 16384;
   localparam longint MASK = 64'h00FF_FFFF;
   localparam real PI   = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst_n, tick, cfg_we, cfg_ch, cfg_en, out_ready, ovr_clr;
   logic [23:0] cfg_ftw, cfg_phase;
   logic [14:0] cfg_amp;
   logic out_valid, out_ch, overrun;
   logic signed [15:0] out_vin, out_vout;
   logic vb_valid, vb_ch, vb_ovr;
   logic signed [15:0] vb_vin, vb_vout;

   always #5 clk = ~clk;

   vac_divider_stim #(.NCH(NCH), .R1_OHM(50), .R2_OHM(50)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_en(cfg_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_vin(out_vin), .out_vout(out_vout), .overrun(overrun), .ovr_clr(ovr_clr));

   vac_divider_stim #(.NCH(NCH), .R1_OHM(150), .R2_OHM(50)) dut_b (
      .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_en(cfg_en),
      .out_valid(vb_valid), .out_ready(out_ready), .out_ch(vb_ch),
      .out_vin(vb_vin), .out_vout(vb_vout), .overrun(vb_ovr), .ovr_clr(ovr_clr));

   typedef struct {
      int ch;
      int vin;
      int vo_a;
      int vo_b;
   } exp_t;

   exp_t   sb[$];
   int     n_pass = 0;
   int     n_total = 0;
   longint m_acc[NCH], m_ftw[NCH], m_phase[NCH], m_amp[NCH];
   bit     m_en[NCH];

   function automatic int lutv(input int j);
      return $rtoi(32767.0 * $sin(PI / 2.0 * real'(j) / 256.0) + 0.5);
   endfunction

   function automatic int sine_of(input longint ph);
      int q, i;
      q = int'((ph >> 22) & 3);
      i = int'((ph >> 14) & 255);
      case (q)
         0: return lutv(i);
         1: return lutv(256 - i);
         2: return -lutv(i);
         default: return -lutv(256 - i);
      endcase
   endfunction

   function automatic int vin_of(input longint ph, input longint amp, input bit en);
      longint p;
      if (!en) return 0;
      p = longint'(sine_of(ph)) * amp;
      return int'(p >>> 15);
   endfunction

   function automatic int vout_of(input int vin, input int k);
      longint p;
      p = longint'(vin) * longint'(k);
      return int'(p >>> 16);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_acc[c] = 0; m_ftw[c] = 0; m_phase[c] = 0; m_amp[c] = 0; m_en[c] = 0;
      end
      sb.delete();
   endtask

   task automatic model_tick(input bit push);
      exp_t e;
      if (push) begin
         for (int c = 0; c < NCH; c++) begin
            e.ch   = c;
            e.vin  = vin_of((m_acc[c] + m_phase[c]) & MASK, m_amp[c], m_en[c]);
            e.vo_a = vout_of(e.vin, KA);
            e.vo_b = vout_of(e.vin, KB);
            sb.push_back(e);
         end
      end
      for (int c = 0; c < NCH; c++)
         if (m_en[c]) m_acc[c] = (m_acc[c] + m_ftw[c]) & MASK;
   endtask

   task automatic cfg_write(input int ch, input longint ftw, input longint ph,
                            input int amp, input bit en);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = ch[0]; cfg_ftw = ftw[23:0]; cfg_phase = ph[23:0];
      cfg_amp = amp[14:0]; cfg_en = en;
      @(negedge clk);
      cfg_we = 1'b0;
      m_ftw[ch] = ftw; m_phase[ch] = ph; m_amp[ch] = amp; m_en[ch] = en;
   endtask

   task automatic do_tick(input bit push);
      @(negedge clk);
      tick = 1'b1;
      model_tick(push);
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic check_beat();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL beat_unexpected ch=%0d vin=%0d required no beat", out_ch, out_vin);
         return;
      end
      e = sb.pop_front();
      $display("beat ch=%0d vin=%0d vout=%0d vout_b=%0d", out_ch, out_vin, out_vout, vb_vout);
      n_total++;
      if (int'(out_ch) !== e.ch) $display("FAIL beat_ch got %0d want %0d", out_ch, e.ch);
      else n_pass++;
      n_total++;
      if (int'(out_vin) !== e.vin) $display("FAIL beat_vin ch%0d got %0d want %0d", e.ch, out_vin, e.vin);
      else n_pass++;
      n_total++;
      if (int'(out_vout) !== e.vo_a) $display("FAIL beat_vout ch%0d got %0d want %0d", e.ch, out_vout, e.vo_a);
      else n_pass++;
      n_total++;
      if (vb_valid !== 1'b1 || int'(vb_vout) !== e.vo_b)
         $display("FAIL beat_vout_ratio ch%0d got valid=%0b %0d want 1 %0d", e.ch, vb_valid, vb_vout, e.vo_b);
      else n_pass++;
   endtask

   task automatic collect(input int nb, input bit chk_lat);
      for (int b = 0; b < nb; b++) begin
         int waited = 0;
         do begin @(negedge clk); waited++; end while (!out_valid && waited < 60);
         if (!out_valid) begin
            n_total++;
            $display("FAIL beat_timeout beat %0d got no valid want valid", b);
            return;
         end
         if (b == 0 && chk_lat) begin
            n_total++;
            if (waited !== 3) $display("FAIL latency got %0d want 3", waited);
            else n_pass++;
         end
         check_beat();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++;
      if ({out_valid, out_ch, overrun, vb_valid} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {out_valid, out_ch, overrun, vb_valid});
      else n_pass++;
      n_total++;
      if (out_vin !== 16'sd0 || out_vout !== 16'sd0) $display("FAIL reset_data got %0d/%0d want 0/0", out_vin, out_vout);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      cfg_write(0, 64'd4194304, 64'd0, 32767, 1'b1);
      cfg_write(1, 64'd4194304, 64'd4194304, 32767, 1'b1);
      for (int f = 0; f < 4; f++) begin
         do_tick(1'b1);
         collect(NCH, 1'b1);
      end
   endtask

   task automatic test_ratio();
      cfg_write(0, 64'd4194304, 64'd4194304, 32767, 1'b1);
      do_tick(1'b1);
      collect(NCH, 1'b1);
      cfg_write(0, 64'd4194304, 64'd0, 32767, 1'b1);
   endtask

   task automatic test_stall();
      exp_t e;
      int waited = 0;
      int seen = 0;
      do_tick(1'b1);
      do begin @(negedge clk); waited++; end while (!out_valid && waited < 60);
      if (!out_valid || sb.size() == 0) begin
         n_total++;
         $display("FAIL stall_timeout got valid=%0b want 1", out_valid);
         return;
      end
      out_ready = 1'b0;
      e = sb.pop_front();
      for (int c = 0; c < 10; c++) begin
         tick = (c == 4);
         if (c == 4) model_tick(1'b0);
         @(negedge clk);
         n_total++;
         if (out_valid !== 1'b1 || int'(out_vin) !== e.vin || int'(out_vout) !== e.vo_a)
            $display("FAIL stall_hold cyc %0d got v=%0b %0d/%0d want 1 %0d/%0d", c, out_valid, out_vin, out_vout, e.vin, e.vo_a);
         else n_pass++;
      end
      tick = 1'b0;
      n_total++;
      if (overrun !== 1'b1 || vb_ovr !== 1'b1) $display("FAIL overrun_set got %b%b want 11", overrun, vb_ovr);
      else n_pass++;
      $display("beat ch=%0d vin=%0d vout=%0d (stalled)", out_ch, out_vin, out_vout);
      out_ready = 1'b1;
      collect(NCH - 1, 1'b0);
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_total++;
      if (seen !== 0) $display("FAIL no_extra_frame got %0d valid cycles want 0", seen);
      else n_pass++;
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      n_total++;
      if (overrun !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun);
      else n_pass++;
      do_tick(1'b1);
      collect(NCH, 1'b1);
   endtask

   task automatic test_disable();
      cfg_write(1, 64'd4194304, 64'd4194304, 32767, 1'b0);
      for (int f = 0; f < 2; f++) begin
         do_tick(1'b1);
         collect(NCH, 1'b1);
      end
      cfg_write(1, 64'd4194304, 64'd4194304, 32767, 1'b1);
      for (int f = 0; f < 2; f++) begin
         do_tick(1'b1);
         collect(NCH, 1'b1);
      end
   endtask

   task automatic test_reset_midframe();
      int waited = 0;
      do_tick(1'b0);
      do begin @(negedge clk); waited++; end while (!out_valid && waited < 60);
      out_ready = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      n_total++;
      if (out_valid !== 1'b1 || overrun !== 1'b1) $display("FAIL pre_reset got v=%b ovr=%b want 1 1", out_valid, overrun);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || overrun !== 1'b0 || vb_valid !== 1'b0)
         $display("FAIL reset_midframe got v=%b ovr=%b vb=%b want 0 0 0", out_valid, overrun, vb_valid);
      else n_pass++;
      model_reset();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_basic();
   endtask

   initial begin
      rst_n = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_ftw = '0;
      cfg_phase = '0; cfg_amp = '0; cfg_en = 1'b0; out_ready = 1'b1; ovr_clr = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      test_reset();
      test_basic();
      test_ratio();
      test_stall();
      test_disable();
      test_reset_midframe();
      n_total++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
